// File: rtl/multicycle_cu_if.sv
// Control-unit bus: opcode/zero flag in from the IR/ALU, control strobes
// and status out to the datapath. master = control unit, slave = datapath.
interface multicycle_cu_if #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
);
  logic [5:0]         op;
  logic               zero;
  logic               PCWre;
  logic [1:0]         PCSrc;
  logic               InsMemRW;
  logic               IRWre;
  logic               ExtSel;
  logic               ALUSrcB;
  logic [ALUOP_W-1:0] ALUOp;
  logic               RegOut;
  logic               RegWre;
  logic               ALUM2Reg;
  logic               DataMemRW;
  logic               halted;
  logic               illegal;
  logic               retire;
  logic [CNT_W-1:0]   retired_cnt;

  modport master (
    input  op, zero,
    output PCWre, PCSrc, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp, RegOut,
           RegWre, ALUM2Reg, DataMemRW, halted, illegal, retire, retired_cnt
  );

  modport slave (
    output op, zero,
    input  PCWre, PCSrc, InsMemRW, IRWre, ExtSel, ALUSrcB, ALUOp, RegOut,
           RegWre, ALUM2Reg, DataMemRW, halted, illegal, retire, retired_cnt
  );
endinterface

// File: rtl/multicycle_cu.sv
// Multi-cycle CPU control unit: walks each instruction through
// IF/ID/EXE/MEM/WB so every write strobe fires only in its own state.
// Also handles jumps, halt, illegal opcodes and counts retired instructions.
module multicycle_cu #(
  parameter int ALUOP_W = 3,
  parameter int CNT_W   = 32
) (
  input logic             clk,
  input logic             rst_n,
  multicycle_cu_if.master bus
);
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ORI  = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_OR   = 6'b010010;
  localparam logic [5:0] OP_MOVE = 6'b100000;
  localparam logic [5:0] OP_SLT  = 6'b101010;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_SW   = 6'b100110;
  localparam logic [5:0] OP_LW   = 6'b100111;
  localparam logic [5:0] OP_BEQ  = 6'b110000;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  typedef enum logic [3:0] {
    S_IF, S_ID, S_EXE_R, S_WB_R, S_EXE_LS, S_MEM, S_WB_LW, S_EXE_BEQ, S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [5:0]       op_q;
  logic [CNT_W-1:0] cnt_q;

  logic       pcwre, insm, irwre, ext, srcb, regout, regwre, m2r, dmw;
  logic       halted, illegal, retire;
  logic [1:0] pcsrc;
  logic [2:0] aluop;

  function automatic logic is_rgrp(input logic [5:0] o);
    logic r;
    case (o)
      OP_ADD, OP_SUB, OP_ORI, OP_AND, OP_OR, OP_MOVE, OP_SLT, OP_SLTI: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // State register, opcode latched at the end of ID, retired counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IF;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) op_q <= bus.op;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Next-state and control decode; ID decodes live op, later states use op_q
  always_comb begin
    state_d = state_q;
    pcwre   = 1'b0;
    pcsrc   = 2'b00;
    insm    = 1'b0;
    irwre   = 1'b0;
    ext     = 1'b0;
    srcb    = 1'b0;
    aluop   = 3'b000;
    regout  = 1'b0;
    regwre  = 1'b0;
    m2r     = 1'b0;
    dmw     = 1'b0;
    halted  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IF: begin
        insm    = 1'b1;
        irwre   = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        if (is_rgrp(bus.op))                       state_d = S_EXE_R;
        else if (bus.op == OP_SW || bus.op == OP_LW) state_d = S_EXE_LS;
        else if (bus.op == OP_BEQ)                 state_d = S_EXE_BEQ;
        else if (bus.op == OP_HALT)                state_d = S_HALT;
        else begin
          // Jump and illegal opcodes both finish here; only j redirects the PC
          state_d = S_IF;
          pcwre   = 1'b1;
          if (bus.op == OP_J) pcsrc = 2'b10;
          else                illegal = 1'b1;
        end
      end
      S_EXE_R, S_WB_R: begin
        case (op_q)
          OP_ADD, OP_MOVE: begin aluop = 3'b000; regout = 1'b1; end
          OP_SUB:          begin aluop = 3'b001; regout = 1'b1; end
          OP_AND:          begin aluop = 3'b010; regout = 1'b1; end
          OP_OR:           begin aluop = 3'b011; regout = 1'b1; end
          OP_SLT:          begin aluop = 3'b100; regout = 1'b1; end
          OP_ORI:          begin aluop = 3'b011; srcb = 1'b1; end
          OP_SLTI:         begin aluop = 3'b100; srcb = 1'b1; ext = 1'b1; end
          default:         aluop = 3'b000;
        endcase
        if (state_q == S_WB_R) begin
          regwre  = 1'b1;
          pcwre   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXE_LS: begin
        srcb    = 1'b1;
        ext     = 1'b1;
        state_d = S_MEM;
      end
      S_MEM: begin
        srcb = 1'b1;
        ext  = 1'b1;
        if (op_q == OP_SW) begin
          dmw     = 1'b1;
          pcwre   = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_WB_LW;
        end
      end
      S_WB_LW: begin
        srcb    = 1'b1;
        ext     = 1'b1;
        m2r     = 1'b1;
        regwre  = 1'b1;
        pcwre   = 1'b1;
        state_d = S_IF;
      end
      S_EXE_BEQ: begin
        aluop   = 3'b001;
        ext     = 1'b1;
        pcwre   = 1'b1;
        pcsrc   = bus.zero ? 2'b01 : 2'b00;
        state_d = S_IF;
      end
      S_HALT: halted = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  // An instruction retires on its PC update, except the illegal-opcode skip
  assign retire = pcwre & ~illegal;

  assign bus.PCWre       = pcwre;
  assign bus.PCSrc       = pcsrc;
  assign bus.InsMemRW    = insm;
  assign bus.IRWre       = irwre;
  assign bus.ExtSel      = ext;
  assign bus.ALUSrcB     = srcb;
  assign bus.ALUOp       = ALUOP_W'(aluop);
  assign bus.RegOut      = regout;
  assign bus.RegWre      = regwre;
  assign bus.ALUM2Reg    = m2r;
  assign bus.DataMemRW   = dmw;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal;
  assign bus.retire      = retire;
  assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_multicycle_cu.sv
// Bench for multicycle_cu: per-cycle expected control vectors are queued
// as each instruction is scheduled and compared cycle by cycle.
module tb_multicycle_cu;
  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ORI = 6'b010000;
  localparam logic [5:0] AND_ = 6'b010001, OR_ = 6'b010010, MOVE = 6'b100000;
  localparam logic [5:0] SLT = 6'b101010, SLTI = 6'b001010, SW = 6'b100110;
  localparam logic [5:0] LW = 6'b100111, BEQ = 6'b110000, J = 6'b111000;
  localparam logic [5:0] HALT = 6'b111111, BADOP = 6'b011111;

  typedef struct packed {
    logic       pcwre;
    logic [1:0] pcsrc;
    logic       insm;
    logic       irwre;
    logic       ext;
    logic       srcb;
    logic [2:0] aluop;
    logic       regout;
    logic       regwre;
    logic       m2r;
    logic       dmw;
    logic       halted;
    logic       illegal;
    logic       retire;
  } ctl_t;

  typedef struct packed {
    logic [5:0] op;
    logic       zero;
  } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  multicycle_cu_if #(.ALUOP_W(3), .CNT_W(32)) bus ();
  multicycle_cu_if #(.ALUOP_W(3), .CNT_W(2))  bus2 ();

  assign bus2.op   = bus.op;
  assign bus2.zero = bus.zero;

  multicycle_cu #(.ALUOP_W(3), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.master)
  );
  multicycle_cu #(.ALUOP_W(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.master)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_cnt = '0;
  ctl_t  exp_q[$];
  stim_t stim_q[$];
  ctl_t  e, a;
  stim_t s;

  function automatic ctl_t sample();
    ctl_t c;
    c.pcwre   = bus.PCWre;
    c.pcsrc   = bus.PCSrc;
    c.insm    = bus.InsMemRW;
    c.irwre   = bus.IRWre;
    c.ext     = bus.ExtSel;
    c.srcb    = bus.ALUSrcB;
    c.aluop   = bus.ALUOp;
    c.regout  = bus.RegOut;
    c.regwre  = bus.RegWre;
    c.m2r     = bus.ALUM2Reg;
    c.dmw     = bus.DataMemRW;
    c.halted  = bus.halted;
    c.illegal = bus.illegal;
    c.retire  = bus.retire;
    return c;
  endfunction

  function automatic ctl_t c_if();
    ctl_t c = '0;
    c.insm  = 1'b1;
    c.irwre = 1'b1;
    return c;
  endfunction

  // Schedule one instruction: stimulus per cycle plus the expected outputs.
  task automatic push_instr(input logic [5:0] op, input logic zero, input logic [5:0] late);
    ctl_t c = '0;
    stim_q.push_back({op, zero});
    exp_q.push_back(c_if());
    stim_q.push_back({op, zero});
    case (op)
      J: begin
        c.pcwre = 1'b1; c.pcsrc = 2'b10; c.retire = 1'b1;
        exp_q.push_back(c); exp_cnt++;
      end
      HALT: exp_q.push_back(c);
      BEQ: begin
        exp_q.push_back(c);
        c.aluop = 3'b001; c.ext = 1'b1; c.pcwre = 1'b1; c.retire = 1'b1;
        c.pcsrc = zero ? 2'b01 : 2'b00;
        stim_q.push_back({late, zero}); exp_q.push_back(c); exp_cnt++;
      end
      LW, SW: begin
        exp_q.push_back(c);
        c.srcb = 1'b1; c.ext = 1'b1;
        stim_q.push_back({late, zero}); exp_q.push_back(c);
        if (op == SW) begin
          c.dmw = 1'b1; c.pcwre = 1'b1; c.retire = 1'b1;
          stim_q.push_back({late, zero}); exp_q.push_back(c);
        end else begin
          stim_q.push_back({late, zero}); exp_q.push_back(c);
          c.m2r = 1'b1; c.regwre = 1'b1; c.pcwre = 1'b1; c.retire = 1'b1;
          stim_q.push_back({late, zero}); exp_q.push_back(c);
        end
        exp_cnt++;
      end
      ADD, MOVE, SUB, AND_, OR_, SLT, ORI, SLTI: begin
        exp_q.push_back(c);
        case (op)
          ADD, MOVE: begin c.aluop = 3'd0; c.regout = 1'b1; end
          SUB:       begin c.aluop = 3'd1; c.regout = 1'b1; end
          AND_:      begin c.aluop = 3'd2; c.regout = 1'b1; end
          OR_:       begin c.aluop = 3'd3; c.regout = 1'b1; end
          SLT:       begin c.aluop = 3'd4; c.regout = 1'b1; end
          ORI:       begin c.aluop = 3'd3; c.srcb = 1'b1; end
          default:   begin c.aluop = 3'd4; c.srcb = 1'b1; c.ext = 1'b1; end
        endcase
        stim_q.push_back({late, zero}); exp_q.push_back(c);
        c.regwre = 1'b1; c.pcwre = 1'b1; c.retire = 1'b1;
        stim_q.push_back({late, zero}); exp_q.push_back(c);
        exp_cnt++;
      end
      default: begin
        c.pcwre = 1'b1; c.illegal = 1'b1;
        exp_q.push_back(c);
      end
    endcase
  endtask

  task automatic test_reset();
    bus.op = ADD; bus.zero = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sample() !== c_if()) begin
      bad++; $display("FAIL reset_outputs act=%h exp=%h", sample(), c_if());
    end
    total++;
    if (bus.retired_cnt !== 32'd0 || bus2.retired_cnt !== 2'd0) begin
      bad++; $display("FAIL reset_cnt act=%0d/%0d exp=0", bus.retired_cnt, bus2.retired_cnt);
    end
    exp_cnt = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_add();
    int cyc = 0;
    push_instr(ADD, 1'b0, ADD);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL add cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL add_cnt act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_lw_sw();
    int cyc = 0;
    push_instr(LW, 1'b0, LW);
    push_instr(SW, 1'b1, SW);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL lw_sw cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL lw_sw_cnt act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_beq_j();
    int cyc = 0;
    push_instr(BEQ, 1'b1, BEQ);
    push_instr(BEQ, 1'b0, BEQ);
    push_instr(J, 1'b0, J);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL beq_j cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL beq_j_cnt act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_alu_ops();
    int cyc = 0;
    push_instr(SLTI, 1'b0, HALT);
    push_instr(ORI, 1'b0, BADOP);
    push_instr(SUB, 1'b0, SUB);
    push_instr(AND_, 1'b0, AND_);
    push_instr(OR_, 1'b0, OR_);
    push_instr(SLT, 1'b0, SLT);
    push_instr(MOVE, 1'b0, J);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL alu_ops cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL alu_ops_cnt act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_illegal_halt();
    int cyc = 0;
    ctl_t h = '0;
    h.halted = 1'b1;
    push_instr(BADOP, 1'b0, BADOP);
    push_instr(HALT, 1'b0, HALT);
    for (int i = 0; i < 20; i++) begin
      stim_q.push_back({ADD, 1'b1});
      exp_q.push_back(h);
    end
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL illegal_halt cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL illegal_halt_cnt act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int cyc = 0;
    // leave HALT first so the lw starts from IF
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = '0;
    push_instr(LW, 1'b0, LW);
    for (int k = 0; k < 3; k++) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL reset_mid_pre cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++;
      if (k < 2) begin @(posedge clk); #1; end
    end
    exp_q.delete(); stim_q.delete(); exp_cnt = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (sample() !== c_if() || bus.retired_cnt !== 32'd0) begin
      bad++; $display("FAIL reset_mid_async act=%h cnt=%0d exp=%h cnt=0", sample(), bus.retired_cnt, c_if());
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); total++;
      if (sample() !== c_if()) begin
        bad++; $display("FAIL reset_mid_hold cyc=%0d act=%h exp=%h", k, sample(), c_if());
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
    cyc = 0;
    push_instr(ADD, 1'b0, ADD);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL reset_mid_post cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus.retired_cnt !== 32'd1) begin
      bad++; $display("FAIL reset_mid_cnt act=%0d exp=1", bus.retired_cnt);
    end
  endtask

  task automatic test_wrap();
    int cyc = 0;
    #2 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    exp_cnt = '0;
    for (int i = 0; i < 5; i++) push_instr(J, 1'b0, J);
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front(); bus.op = s.op; bus.zero = s.zero;
      @(negedge clk);
      e = exp_q.pop_front(); a = sample(); total++;
      if (a !== e) begin bad++; $display("FAIL wrap cyc=%0d act=%h exp=%h", cyc, a, e); end
      cyc++; @(posedge clk); #1;
    end
    total++;
    if (bus2.retired_cnt !== 2'd1) begin
      bad++; $display("FAIL wrap_cnt2 act=%0d exp=1", bus2.retired_cnt);
    end
    total++;
    if (bus.retired_cnt !== exp_cnt) begin
      bad++; $display("FAIL wrap_cnt32 act=%0d exp=%0d", bus.retired_cnt, exp_cnt);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_beq_j();
    test_alu_ops();
    test_illegal_halt();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_cu.md
Name: multicycle_cu

Overview:
- Multi-cycle successor to the single-cycle CPU control unit.
- Sequences each instruction through IF/ID/EXE/MEM/WB states, so register-file writes, data-memory writes and PC updates are each asserted only in their own state.
- Adds jump support, halt latching, illegal-opcode handling and a retired-instruction counter.
- Sits between the instruction register (opcode, zero flag from ALU) and the datapath muxes, PC, IR, register file and data memory.

Parameters:
- ALUOP_W, 3, ALUOp output width; codes below occupy the low 3 bits, upper bits are 0; must be >=3.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from IR; valid from ID onward
- zero  in  1  ALU zero flag
- PCWre  out  1  PC load enable
- PCSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- InsMemRW  out  1  1 = instruction memory read
- IRWre  out  1  IR load enable
- ExtSel  out  1  1 = sign-extend, 0 = zero-extend
- ALUSrcB  out  1  1 = immediate, 0 = rt data
- ALUOp  out  ALUOP_W  000 add, 001 sub, 010 and, 011 or, 100 slt
- RegOut  out  1  1 = rd, 0 = rt as write destination
- RegWre  out  1  register-file write enable
- ALUM2Reg  out  1  1 = memory data to register, 0 = ALU result
- DataMemRW  out  1  1 = write, 0 = read
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse, unknown opcode decoded
- retire  out  1  one-cycle pulse, instruction completed
- retired_cnt  out  CNT_W  completed-instruction count; wraps modulo 2^CNT_W

Behaviour:
- Opcodes:
  - add 000000, sub 000001, ori 010000, and 010001, or 010010, move 100000
  - slt 101010, slti 001010, sw 100110, lw 100111, beq 110000, j 111000, halt 111111
  - Any other value is illegal.
- States: IF, ID, EXE_R, WB_R, EXE_LS, MEM, WB_LW, EXE_BEQ, HALT.
- op is registered into op_q on the ID->next edge; EXE/MEM/WB decode uses op_q, so op may change after ID.
- Transitions from ID:
  - R/imm-ALU group (add, sub, and, or, ori, move, slt, slti): ->EXE_R->WB_R->IF.
  - sw/lw: ->EXE_LS->MEM; sw returns to IF, lw continues ->WB_LW->IF.
  - beq: ->EXE_BEQ->IF.
  - j: ->IF.
  - halt: ->HALT, which holds until reset.
  - illegal: ->IF.
- Latency in cycles including IF: j 2, illegal 2, beq 3, R-group 4, sw 4, lw 5.
- All outputs are combinational from state/op/op_q/zero.
- Default for every control output is 0, except InsMemRW, IRWre and ALUOp where stated below.
- IF: InsMemRW=1, IRWre=1.
- ID:
  - j: PCWre=1, PCSrc=10.
  - Illegal: PCWre=1, PCSrc=00, illegal=1.
- EXE_R/WB_R: ALUOp and ALUSrcB/ExtSel held through both states.
  - add, move: ALUOp 000, ALUSrcB 0.
  - sub: ALUOp 001, ALUSrcB 0.
  - and: ALUOp 010, ALUSrcB 0.
  - or: ALUOp 011, ALUSrcB 0.
  - slt: ALUOp 100, ALUSrcB 0.
  - ori: ALUOp 011, ALUSrcB 1, ExtSel 0.
  - slti: ALUOp 100, ALUSrcB 1, ExtSel 1.
  - RegOut=1 for add, sub, and, or, move, slt; RegOut=0 for ori, slti.
  - WB_R additionally: RegWre=1, PCWre=1, PCSrc=00.
- EXE_LS/MEM/WB_LW: ALUOp 000, ALUSrcB 1, ExtSel 1.
  - MEM for sw: DataMemRW=1, PCWre=1.
  - WB_LW: ALUM2Reg=1, RegWre=1, RegOut=0, PCWre=1.
- EXE_BEQ: ALUOp 001, ALUSrcB 0, ExtSel 1, PCWre=1, PCSrc = zero ? 01 : 00.
- HALT: all enables 0, halted=1. PCWre and RegWre are never asserted in HALT.
- retire=1 in exactly the cycle PCWre=1 for a legal instruction. It is not asserted for illegal opcodes or for halt.
- retired_cnt increments on that edge.
- Reset (async, any state, including mid-instruction): state=IF, op_q=0, retired_cnt=0.
  - Outputs immediately show IF values: InsMemRW=1, IRWre=1, all others 0.
  - A partially executed instruction produces no RegWre/DataMemRW/PCWre.

Test Plan:
- Reset, then add (000000): IF,ID,EXE_R,WB_R. RegWre=1 and PCWre=1 only in cycle 4, RegOut=1, ALUOp=000. retired_cnt 0->1.
- lw (100111) then sw (100110): lw gives RegWre+ALUM2Reg in cycle 5 only. sw gives DataMemRW=1 in cycle 4 with RegWre=0 throughout. retired_cnt=2.
- beq with zero=1 then zero=0: PCSrc=01 then 00 in cycle 3, PCWre=1 both times. j (111000): PCWre=1, PCSrc=10 in cycle 2.
- slti (001010) with op driven to 111111 after ID: ALUOp=100, ALUSrcB=1, ExtSel=1, RegOut=0. Decode stays slti from op_q.
- Illegal op 011111: illegal pulse in ID, PCWre=1, PCSrc=00, retire=0, back to IF. Then halt: halted=1 for 20 cycles, no enables. Release only by rst_n.
- rst_n pulsed low during EXE_LS of lw: no RegWre ever. IF outputs appear asynchronously, retired_cnt=0.
- CNT_W=2: retire 5 instructions -> retired_cnt=1 (wrap).
